// File: rtl/rpn_ctrl.sv
// RPN calculator sequencer: accumulates decimal literals, runs an operand stack and pops results on LF.
// Optional signed divider enabled by defining RPN_CTRL_DIV_EN.
module rpn_ctrl #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             is_space,
    input  logic             is_op,
    input  logic [3:0]       digit,
    input  logic [3:0]       op,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    input  logic             res_ready,
    output logic             err,
    output logic [1:0]       err_code
);
    localparam int unsigned SPW = $clog2(DEPTH + 1);
    localparam int unsigned IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_POP = 4'd4;

    localparam logic [1:0] E_BAD = 2'd0;
    localparam logic [1:0] E_OVF = 2'd1;
    localparam logic [1:0] E_UNF = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_OUT, S_ERR} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             num_q, num_d;
    logic [SPW-1:0]   sp_q, sp_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             in_ready_q, res_valid_q, err_q;

    logic [WIDTH-1:0] stack_q [DEPTH];
    logic             stk_we;
    logic [IW-1:0]    stk_idx;
    logic [WIDTH-1:0] stk_wdata;

    logic [WIDTH-1:0] opa, opb, alu;
    logic             is_digit, op_ok;

    assign is_digit = !is_space && !is_op && (digit <= 4'd9);
    assign opa = stack_q[IW'(sp_q - SPW'(2))];
    assign opb = stack_q[IW'(sp_q - SPW'(1))];

`ifdef RPN_CTRL_DIV_EN
    localparam logic [1:0] E_DIV0 = 2'd3;
    logic [WIDTH-1:0] quot;
    // Divide by -1 is negation so MIN/-1 wraps to MIN without relying on divider overflow.
    assign quot  = (opb == '1) ? (WIDTH'(0) - opa) : WIDTH'($signed(opa) / $signed(opb));
    assign op_ok = (op <= OP_POP);
`else
    assign op_ok = (op <= OP_POP) && (op != OP_DIV);
`endif

    // Binary operator result for stack[sp-2] op stack[sp-1]
    always_comb begin
        alu = '0;
        case (op_q)
            OP_ADD:  alu = opa + opb;
            OP_SUB:  alu = opa - opb;
            OP_MUL:  alu = opa * opb;
`ifdef RPN_CTRL_DIV_EN
            OP_DIV:  alu = quot;
`endif
            default: alu = '0;
        endcase
    end

    // Next-state, datapath updates and stack write port
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        num_d      = num_q;
        sp_d       = sp_q;
        op_d       = op_q;
        res_data_d = res_data_q;
        err_code_d = err_code_q;
        stk_we     = 1'b0;
        stk_idx    = IW'(sp_q);
        stk_wdata  = acc_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (is_digit) begin
                        acc_d = acc_q * WIDTH'(10) + WIDTH'(digit);
                        num_d = 1'b1;
                    end else if (is_space || is_op) begin
                        if (num_q && (sp_q == SP_FULL)) begin
                            state_d    = S_ERR;
                            err_code_d = E_OVF;
                        end else begin
                            if (num_q) begin
                                stk_we = 1'b1;
                                sp_d   = sp_q + SPW'(1);
                                acc_d  = '0;
                                num_d  = 1'b0;
                            end
                            if (!is_space) begin
                                if (op_ok) begin
                                    op_d    = op;
                                    state_d = S_EXEC;
                                end else begin
                                    state_d    = S_ERR;
                                    err_code_d = E_BAD;
                                end
                            end
                        end
                    end else begin
                        state_d    = S_ERR;
                        err_code_d = E_BAD;
                    end
                end
            end
            S_EXEC: begin
                if (op_q == OP_POP) begin
                    if (sp_q == '0) begin
                        state_d    = S_ERR;
                        err_code_d = E_UNF;
                    end else begin
                        res_data_d = opb;
                        sp_d       = sp_q - SPW'(1);
                        state_d    = S_OUT;
                    end
                end else if (sp_q < SPW'(2)) begin
                    state_d    = S_ERR;
                    err_code_d = E_UNF;
`ifdef RPN_CTRL_DIV_EN
                end else if ((op_q == OP_DIV) && (opb == '0)) begin
                    state_d    = S_ERR;
                    err_code_d = E_DIV0;
`endif
                end else begin
                    stk_we    = 1'b1;
                    stk_idx   = IW'(sp_q - SPW'(2));
                    stk_wdata = alu;
                    sp_d      = sp_q - SPW'(1);
                    state_d   = S_IDLE;
                end
            end
            S_OUT: begin
                if (res_ready) state_d = S_IDLE;
            end
            S_ERR: begin
                if (in_valid && is_op && (op == OP_POP)) begin
                    sp_d    = '0;
                    acc_d   = '0;
                    num_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            num_q       <= 1'b0;
            sp_q        <= '0;
            op_q        <= '0;
            res_data_q  <= '0;
            err_code_q  <= '0;
            in_ready_q  <= 1'b1;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            num_q       <= num_d;
            sp_q        <= sp_d;
            op_q        <= op_d;
            res_data_q  <= res_data_d;
            err_code_q  <= err_code_d;
            in_ready_q  <= (state_d == S_IDLE) || (state_d == S_ERR);
            res_valid_q <= (state_d == S_OUT);
            err_q       <= (state_d == S_ERR);
        end
    end

    // Stack contents need no reset: sp defines which entries are live
    always_ff @(posedge clk) begin
        if (stk_we) stack_q[stk_idx] <= stk_wdata;
    end

    assign in_ready  = in_ready_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
endmodule
